// File: rtl/bpm_disp_pkg.sv
// Shared types, constants and segment decoder for the BPM seven-segment display.
// Optional stale-blanking feature is enabled with `define BPM_STALE_BLANK_EN.
package bpm_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam int         MAX_BPM   = 999;
    localparam int         BIN_BITS  = 10;

    // Active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bpm_seg_display_bin2bcd.sv
// Sequential double-dabble converter: one shift per cycle, done pulses
// in the cycle that performs the final shift.
module bin2bcd_seq
    import bpm_disp_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [BIN_BITS-1:0] bin_i,
    output logic                done_o,
    output logic [11:0]         bcd_o
);

    logic [BIN_BITS-1:0] bin_q, bin_d;
    logic [11:0]         bcd_q, bcd_d;
    logic [3:0]          cnt_q;
    logic                act_q;
    logic [11:0]         adj;
    logic [21:0]         sh;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        sh    = {adj, bin_q} << 1;
        bcd_d = sh[21:10];
        bin_d = sh[9:0];
    end

    assign done_o = act_q && (cnt_q == 4'(BIN_BITS - 1));
    assign bcd_o  = bcd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b1;
        end else if (act_q) begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_q + 4'd1;
            if (done_o)
                act_q <= 1'b0;
        end
    end

endmodule

// File: rtl/bpm_seg_display.sv
// BPM display: rate-limited BCD conversion, blanked 3-digit 7-seg, beat LED.
// Define BPM_STALE_BLANK_EN to dash the digits when beats stop arriving.
module bpm_seg_display
    import bpm_disp_pkg::*;
#(
    parameter int BPM_WIDTH  = 16,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int UPDATE_HZ  = 4,
    parameter int FLASH_MS   = 100,
    parameter int STALE_MS   = 3000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BPM_WIDTH-1:0] bpm_val,
    input  logic                 beat_detected,
    output logic [6:0]           hex2,
    output logic [6:0]           hex1,
    output logic [6:0]           hex0,
    output logic [11:0]          bcd_out,
    output logic                 beat_led,
    output logic                 busy
);

    localparam int UPDATE_CYCLES = CLOCK_FREQ / UPDATE_HZ;
    localparam int FLASH_CYCLES  = CLOCK_FREQ / 1000 * FLASH_MS;
    localparam int TW = $clog2(UPDATE_CYCLES);
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    logic [TW-1:0] tick_q;
    logic          tick;
    state_e        state_q, state_d;
    logic          start;
    logic          done;
    logic          ovf_in, ovf_q;
    logic [BIN_BITS-1:0] bin_in;
    logic [11:0]   bcd_conv;
    logic          commit;
    logic [6:0]    hex2_q, hex1_q, hex0_q;
    logic [6:0]    hex2_d, hex1_d, hex0_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [FW-1:0] flash_q;

    assign tick = (tick_q == TW'(UPDATE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_q <= '0;
        else if (tick)
            tick_q <= '0;
        else
            tick_q <= tick_q + 1'b1;
    end

    assign ovf_in = (bpm_val > BPM_WIDTH'(MAX_BPM));
    assign bin_in = ovf_in ? '0 : bpm_val[BIN_BITS-1:0];

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT:   if (done) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start)
                ovf_q <= ovf_in;
        end
    end

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .bin_i   (bin_in),
        .done_o  (done),
        .bcd_o   (bcd_conv)
    );

    assign commit = (state_q == COMMIT);
    assign busy   = (state_q != IDLE);

    // Leading-zero blanking; the units digit is always lit.
    always_comb begin
        if (ovf_q) begin
            hex2_d = SEG_DASH;
            hex1_d = SEG_DASH;
            hex0_d = SEG_DASH;
            bcd_d  = 12'h999;
        end else begin
            hex2_d = (bcd_conv[11:8] == 4'd0) ? SEG_BLANK
                                               : seg7_lut(bcd_conv[11:8]);
            hex1_d = (bcd_conv[11:4] == 8'd0) ? SEG_BLANK
                                               : seg7_lut(bcd_conv[7:4]);
            hex0_d = seg7_lut(bcd_conv[3:0]);
            bcd_d  = bcd_conv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex2_q <= SEG_BLANK;
            hex1_q <= SEG_BLANK;
            hex0_q <= SEG_BLANK;
            bcd_q  <= '0;
        end else if (commit) begin
            hex2_q <= hex2_d;
            hex1_q <= hex1_d;
            hex0_q <= hex0_d;
            bcd_q  <= bcd_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flash_q <= '0;
        else if (beat_detected)
            flash_q <= FW'(FLASH_CYCLES);
        else if (flash_q != '0)
            flash_q <= flash_q - 1'b1;
    end

    assign beat_led = (flash_q != '0);
    assign bcd_out  = bcd_q;

`ifdef BPM_STALE_BLANK_EN
    localparam int STALE_CYCLES = CLOCK_FREQ / 1000 * STALE_MS;
    localparam int SW = $clog2(STALE_CYCLES + 1);

    logic [SW-1:0] stale_cnt_q;
    logic          stale_hit;
    logic          stale_q;

    assign stale_hit = (stale_cnt_q == SW'(STALE_CYCLES));

    // Dashes persist until a commit after beats resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            if (beat_detected)
                stale_cnt_q <= '0;
            else if (!stale_hit)
                stale_cnt_q <= stale_cnt_q + 1'b1;
            if (stale_hit)
                stale_q <= 1'b1;
            else if (commit)
                stale_q <= 1'b0;
        end
    end

    assign hex2 = (stale_hit || stale_q) ? SEG_DASH : hex2_q;
    assign hex1 = (stale_hit || stale_q) ? SEG_DASH : hex1_q;
    assign hex0 = (stale_hit || stale_q) ? SEG_DASH : hex0_q;
`else
    assign hex2 = hex2_q;
    assign hex1 = hex1_q;
    assign hex0 = hex0_q;
`endif

endmodule

// File: tb/tb_bpm_seg_display.sv
// Randomized scoreboard bench for bpm_seg_display (default build).
// Tick every 10 cycles, 5-cycle beat flash.
module tb_bpm_seg_display;

    typedef struct {
        logic [6:0]  h2;
        logic [6:0]  h1;
        logic [6:0]  h0;
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bpm_val = '0;
    logic        beat_detected = 1'b0;
    logic [6:0]  hex2, hex1, hex0;
    logic [11:0] bcd_out;
    logic        beat_led;
    logic        busy;

    always #5 clk = ~clk;

    bpm_seg_display #(
        .BPM_WIDTH  (16),
        .CLOCK_FREQ (1000),
        .UPDATE_HZ  (100),
        .FLASH_MS   (5),
        .STALE_MS   (30)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bpm_val       (bpm_val),
        .beat_detected (beat_detected),
        .hex2          (hex2),
        .hex1          (hex1),
        .hex0          (hex0),
        .bcd_out       (bcd_out),
        .beat_led      (beat_led),
        .busy          (busy)
    );

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int directed [7] = '{128, 7, 0, 1000, 65535, 999, 64};

    exp_t q[$];
    int   n;
    int   checks = 0;
    int   fails = 0;
    int   cap = -100;
    int   busy_end = 0;
    int   last_beat = -100;
    int   dir_idx = 0;
    int   commits = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic exp_t model(input int v, input int c);
        exp_t e;
        int h, t, u;
        e.cyc = c;
        if (v > 999) begin
            e.h2 = 7'h3F; e.h1 = 7'h3F; e.h0 = 7'h3F;
            e.bcd = 12'h999;
        end else begin
            h = v / 100;
            t = (v / 10) % 10;
            u = v % 10;
            e.bcd = 12'(h * 256 + t * 16 + u);
            e.h2 = (h == 0) ? 7'h7F : segtab[h];
            e.h1 = (v < 10) ? 7'h7F : segtab[t];
            e.h0 = segtab[u];
        end
        return e;
    endfunction

    // Monitor: a busy falling edge marks a fresh commit.
    initial begin
        logic prev_busy;
        int   blen;
        exp_t e;
        prev_busy = 1'b0;
        blen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                blen = 0;
            end else begin
                if (busy) blen++;
                if (prev_busy && !busy) begin
                    chk("busy_len", blen, 11);
                    blen = 0;
                    if (q.size() == 0) begin
                        chk("unexpected_commit", 1, 0);
                    end else begin
                        e = q.pop_front();
                        commits++;
                        chk("latency", n - e.cyc, 12);
                        chk("hex2", hex2, e.h2);
                        chk("hex1", hex1, e.h1);
                        chk("hex0", hex0, e.h0);
                        chk("bcd_out", bcd_out, e.bcd);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    task automatic pick_val(output int v);
        if (dir_idx < 7) begin
            v = directed[dir_idx];
            dir_idx++;
        end else begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 9));
                1:       v = int'($urandom_range(10, 99));
                2:       v = int'($urandom_range(100, 999));
                default: v = int'($urandom_range(0, 65535));
            endcase
        end
    endtask

    task automatic step();
        int   v;
        logic eb, el;
        eb = (n >= cap + 1) && (n <= cap + 11);
        chk("busy", busy, eb);
        el = (n - last_beat >= 1) && (n - last_beat <= 5);
        chk("beat_led", beat_led, el);
        if ((n % 10 == 9) && (n >= busy_end)) begin
            pick_val(v);
            bpm_val = 16'(v);
            q.push_back(model(v, n));
            cap = n;
            busy_end = n + 12;
        end else if ($urandom_range(0, 3) == 0) begin
            bpm_val = 16'($urandom);
        end
        beat_detected = ($urandom_range(0, 5) == 0);
        if (beat_detected) last_beat = n;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hex2", hex2, 7'h7F);
        chk("rst_hex1", hex1, 7'h7F);
        chk("rst_hex0", hex0, 7'h7F);
        chk("rst_bcd", bcd_out, 12'h000);
        chk("rst_led", beat_led, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (600) begin
            @(negedge clk);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            step();
            if (n == cap + 5) break;
        end
        chk("mid_shift_reached", n, cap + 5);
        reset = 1'b1;
        beat_detected = 1'b0;
        #1;
        chk("mid_rst_hex2", hex2, 7'h7F);
        chk("mid_rst_hex1", hex1, 7'h7F);
        chk("mid_rst_hex0", hex0, 7'h7F);
        chk("mid_rst_bcd", bcd_out, 12'h000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_led", beat_led, 1'b0);
        @(negedge clk);
        @(negedge clk);
        q.delete();
        cap = -100;
        busy_end = 0;
        last_beat = -100;
        reset = 1'b0;
        repeat (80) begin
            @(negedge clk);
            step();
        end
        chk("pending_drained", (q.size() <= 1), 1'b1);
        chk("commits_seen", (commits >= 30), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/bpm_seg_display.md
Name: bpm_seg_display

Overview:
- Downstream consumer of the BPM/beat detector. Takes the smoothed `bpm_val` and the one-cycle `beat_detected` pulse.
- Shows BPM on three active-low seven-segment digits, with leading-zero blanking and an over-range indication.
- Drives a beat-flash LED with a fixed on-time.
- Uses a rate-limited sequential double-dabble binary-to-BCD conversion, so the display does not flicker with every BPM update.

Parameters:
- BPM_WIDTH, 16, width of the `bpm_val` input.
- CLOCK_FREQ, 50_000_000, clk frequency in Hz.
- UPDATE_HZ, 4, display refresh rate. UPDATE_CYCLES = CLOCK_FREQ/UPDATE_HZ.
- FLASH_MS, 100, beat LED on-time. FLASH_CYCLES = CLOCK_FREQ/1000*FLASH_MS.
- STALE_MS, 3000, no-beat timeout. STALE_CYCLES = CLOCK_FREQ/1000*STALE_MS. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- bpm_val  in  BPM_WIDTH  unsigned BPM from the detector
- beat_detected  in  1  one-cycle beat pulse
- hex2  out  7  hundreds digit, active-low {g,f,e,d,c,b,a}
- hex1  out  7  tens digit
- hex0  out  7  units digit
- bcd_out  out  12  committed BPM as BCD {hundreds, tens, units}
- beat_led  out  1  beat flash
- busy  out  1  conversion in progress

Behaviour:
- Clock and reset: clock is clk; reset is `reset`, asynchronous, active-high.
- Reset values:
  - hex2/hex1/hex0 = 7'h7F (blank)
  - bcd_out = 12'h000
  - beat_led = 0, busy = 0
  - all counters = 0, FSM in IDLE
- Reset mid-conversion aborts the conversion with no partial commit.
- Refresh tick:
  - Free-running counter 0..UPDATE_CYCLES-1.
  - `tick` is high in the cycle where count == UPDATE_CYCLES-1; the counter wraps to 0 on the next edge.
  - The first tick occurs UPDATE_CYCLES cycles after reset release.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE, tick: capture `bpm_val`, set `ovf = (bpm_val > 999)`, load the low 10 bits (or 0 if ovf) into the shift register, clear the BCD scratch, shift_cnt = 0, go to SHIFT.
  - IDLE, no tick: stay.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 in the same cycle. shift_cnt increments; after the 10th shift go to COMMIT.
  - COMMIT: write the output registers, then go to IDLE.
  - busy = 1 in SHIFT and COMMIT (11 cycles).
  - Outputs change at the 12th edge after the tick edge.
  - A tick arriving while busy is ignored; UPDATE_CYCLES must be >= 12.
  - `bpm_val` changes after capture do not affect the conversion in flight.
- Commit rules:
  - ovf: all digits = 7'h3F (dash); bcd_out = 12'h999.
  - Otherwise bcd_out = converted value.
  - Hundreds digit blank if 0.
  - Tens digit blank if hundreds and tens are both 0.
  - Units digit always shown, so 0 displays as "  0".
- Segment codes 0-9, active-low: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- Beat LED:
  - A `beat_detected` pulse loads flash_cnt = FLASH_CYCLES; otherwise flash_cnt decrements to 0.
  - beat_led = (flash_cnt != 0), registered, so it rises the edge after the pulse.
  - A pulse while lit retriggers to the full FLASH_CYCLES.
  - The flash is independent of the FSM and the tick.

Optional Feature:
- Macro: BPM_STALE_BLANK_EN.
- Enabled:
  - stale_cnt resets to 0 on each `beat_detected` and otherwise counts up, saturating at STALE_CYCLES.
  - While stale_cnt == STALE_CYCLES, hex2/hex1/hex0 show 7'h3F; bcd_out is unaffected.
  - Dashes are removed at the first COMMIT after a beat clears the condition.
  - After reset the count starts at 0.
- Disabled: no stale counter; the last committed value is held indefinitely.

Decomposition:
- Package `bpm_disp_pkg` holds:
  - state enum {IDLE, SHIFT, COMMIT}
  - constants SEG_BLANK = 7'h7F, SEG_DASH = 7'h3F, MAX_BPM = 999, BIN_BITS = 10
  - function seg7_lut(logic [3:0]) returning 7'b code
- Sub-module `bin2bcd_seq` holds the double-dabble shifter and shift counter, with a start/done handshake. The top level owns the tick, clamp, blanking, flash and stale logic.

Test Plan:
Bench parameters: CLOCK_FREQ = 1000, UPDATE_HZ = 100 (tick every 10 cycles), FLASH_MS = 5 (5 cycles), STALE_MS = 30.
1. bpm_val = 128, wait one tick -> 12 cycles later hex2 = 79, hex1 = 24, hex0 = 00, bcd_out = 12'h128; busy high for exactly 11 cycles.
2. bpm_val = 7 -> hex2 = hex1 = 7F, hex0 = 78, bcd_out = 12'h007. bpm_val = 0 -> hex0 = 40, others 7F.
3. bpm_val = 1000, then 16'hFFFF -> all digits 3F, bcd_out = 12'h999. bpm_val = 999 -> 10, 10, 10.
4. beat pulse at cycle t -> beat_led high cycles t+1..t+5. Second pulse at t+3 -> beat_led high t+1..t+8, then 0.
5. Change bpm_val 128 -> 64 during SHIFT -> commit shows 128; the next tick shows 64. Assert reset mid-SHIFT -> immediate 7F/0/busy = 0, and the first tick comes 10 cycles after release.
6. BPM_STALE_BLANK_EN: value 120 displayed, no beats for 30 cycles -> dashes, bcd_out = 12'h120; a beat followed by the next commit -> "120" restored.
